band_corr_acc: RTL and testbench

//  Successor to the fixed band DoA accumulator. Takes per-lane correlation products
//  (pow0, pow1, corr_re, corr_im) from PARALLEL lanes and sums the lanes. It then

---
 rtl/band_corr_acc.sv | 254 +++++++++++++++++++++++++
 tb/tb_band_corr_acc.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/band_corr_acc.sv
// band_corr_acc: sums per-lane correlation products, integrates them per band
// over a programmable number of spectra and streams the band results out on a
// valid/ready handshake through a single-result shadow buffer.
module band_corr_acc #(
  parameter int DIN_WIDTH     = 35,
  parameter int PARALLEL      = 4,
  parameter int VECTOR_LEN    = 64,
  parameter int BANDS         = 4,
  parameter int PRE_SHIFT     = 0,
  parameter int ACC_WIDTH     = 32,
  parameter int ACC_LEN_WIDTH = 16,
  localparam int BW = (BANDS > 1) ? $clog2(BANDS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PARALLEL*DIN_WIDTH-1:0] pow0,
  input  logic [PARALLEL*DIN_WIDTH-1:0] pow1,
  input  logic [PARALLEL*DIN_WIDTH-1:0] corr_re,
  input  logic [PARALLEL*DIN_WIDTH-1:0] corr_im,
  input  logic                          din_valid,
  input  logic                          sync,
  input  logic [ACC_LEN_WIDTH-1:0]      acc_len,
  input  logic                          clr_overrun,
  output logic signed [ACC_WIDTH-1:0]   r11,
  output logic signed [ACC_WIDTH-1:0]   r22,
  output logic signed [ACC_WIDTH-1:0]   r12_re,
  output logic signed [ACC_WIDTH-1:0]   r12_im,
  output logic [BW-1:0]                 band_number,
  output logic                          dout_sat,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          overrun
);

  localparam int CHANS     = VECTOR_LEN / PARALLEL;
  localparam int BAND_STEP = CHANS / BANDS;
  localparam int SW        = DIN_WIDTH + $clog2(PARALLEL);
  localparam int CW        = $clog2(CHANS + 1);
  localparam int FW        = ((SW > ACC_WIDTH) ? SW : ACC_WIDTH) + 1;
  localparam logic [CW-1:0] CHANS_C = CW'(CHANS);
  localparam logic [CW-1:0] LAST_C  = CW'(CHANS - 1);
  localparam logic [ACC_LEN_WIDTH-1:0] LEN_ZERO = {ACC_LEN_WIDTH{1'b0}};
  localparam logic [ACC_LEN_WIDTH-1:0] LEN_ONE  = {{(ACC_LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [FW-1:0] MAX_F = {{(FW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [FW-1:0] MIN_F = {{(FW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH-1:0] MAX_A = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] MIN_A = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {I_WAIT, I_ACC} in_state_t;
  typedef enum logic [1:0] {O_EMPTY, O_LOAD, O_SEND} out_state_t;

  // Saturating add (or load when starting a band); returns {overflow, value}.
  function automatic logic [ACC_WIDTH:0] sat_add(
    input logic signed [ACC_WIDTH-1:0] acc_v,
    input logic signed [SW-1:0]        sum_v,
    input logic                        load
  );
    logic signed [FW-1:0] base;
    logic signed [FW-1:0] t;
    logic [ACC_WIDTH:0]   res;
    if (load) base = {FW{1'b0}};
    else      base = FW'(acc_v);
    t = base + FW'(sum_v);
    if (t > MAX_F)      res = {1'b1, MAX_A};
    else if (t < MIN_F) res = {1'b1, MIN_A};
    else                res = {1'b0, t[ACC_WIDTH-1:0]};
    return res;
  endfunction

  in_state_t                  in_state_r;
  out_state_t                 out_state_r;
  logic [CW-1:0]              chan_cnt_r;
  logic [ACC_LEN_WIDTH-1:0]   spec_cnt_r, acc_len_r;
  logic [PARALLEL*DIN_WIDTH-1:0] din_q_s [4];
  logic signed [SW-1:0]       lane_sum_s [4];
  logic signed [SW-1:0]       s1_sum_r [4];
  logic                       s1_valid_r, s1_end_r, done_r;
  logic [BW-1:0]              s1_band_r, band_s, next_band_s;
  logic                       beat_ok_s, first_sync_s, end_beat_s, first_s, ovf_s;
  logic [CW-1:0]              eff_chan_s;
  logic [ACC_LEN_WIDTH-1:0]   spec_eff_s, len_eff_s, len_in_s, spec_next_s;
  logic [ACC_WIDTH:0]         upd_s [4];
  logic signed [ACC_WIDTH-1:0] acc_r [4][BANDS];
  logic signed [ACC_WIDTH-1:0] shadow_r [4][BANDS];
  logic [BANDS-1:0]           hit_r, sat_r, sh_sat_r;

  // Lane adder tree input: sign-extend each lane and sum per quantity.
  always_comb begin
    din_q_s[0] = pow0;
    din_q_s[1] = pow1;
    din_q_s[2] = corr_re;
    din_q_s[3] = corr_im;
    for (int q = 0; q < 4; q++) begin
      lane_sum_s[q] = {SW{1'b0}};
      for (int l = 0; l < PARALLEL; l++) begin
        lane_sum_s[q] = lane_sum_s[q] + SW'($signed(din_q_s[q][l*DIN_WIDTH +: DIN_WIDTH]));
      end
    end
  end

  // Beat qualification: channel index, band, and integration-end detection.
  always_comb begin
    len_in_s     = (acc_len == LEN_ZERO) ? LEN_ONE : acc_len;
    spec_next_s  = (spec_cnt_r == acc_len_r - LEN_ONE) ? spec_cnt_r : spec_cnt_r + LEN_ONE;
    beat_ok_s    = 1'b0;
    first_sync_s = 1'b0;
    eff_chan_s   = chan_cnt_r;
    spec_eff_s   = spec_cnt_r;
    len_eff_s    = acc_len_r;
    if (din_valid && sync) begin
      beat_ok_s  = 1'b1;
      eff_chan_s = {CW{1'b0}};
      if (in_state_r == I_WAIT) begin
        first_sync_s = 1'b1;
        spec_eff_s   = LEN_ZERO;
        len_eff_s    = len_in_s;
      end else begin
        spec_eff_s   = spec_next_s;
      end
    end else if (din_valid && (in_state_r == I_ACC) && (chan_cnt_r < CHANS_C)) begin
      beat_ok_s = 1'b1;
    end else begin
      beat_ok_s = 1'b0;
    end
    end_beat_s = beat_ok_s && (eff_chan_s == LAST_C) && (spec_eff_s == len_eff_s - LEN_ONE);
    band_s     = BW'(eff_chan_s / CW'(BAND_STEP));
  end

  // Input FSM, channel/spectrum counters and the registered lane-sum stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_r <= I_WAIT;
      chan_cnt_r <= {CW{1'b0}};
      spec_cnt_r <= LEN_ZERO;
      acc_len_r  <= LEN_ZERO;
      s1_valid_r <= 1'b0;
      s1_end_r   <= 1'b0;
      s1_band_r  <= {BW{1'b0}};
      for (int q = 0; q < 4; q++) s1_sum_r[q] <= {SW{1'b0}};
    end else begin
      s1_valid_r <= beat_ok_s;
      s1_end_r   <= end_beat_s;
      s1_band_r  <= band_s;
      for (int q = 0; q < 4; q++) s1_sum_r[q] <= lane_sum_s[q] >>> PRE_SHIFT;
      if (din_valid && sync) chan_cnt_r <= CW'(1);
      else if (din_valid && (chan_cnt_r < CHANS_C)) chan_cnt_r <= chan_cnt_r + CW'(1);
      case (in_state_r)
        I_WAIT: begin
          if (first_sync_s) begin
            acc_len_r  <= len_in_s;
            spec_cnt_r <= LEN_ZERO;
            in_state_r <= end_beat_s ? I_WAIT : I_ACC;
          end
        end
        I_ACC: begin
          if (din_valid && sync) spec_cnt_r <= spec_next_s;
          if (end_beat_s) in_state_r <= I_WAIT;
        end
        default: in_state_r <= I_WAIT;
      endcase
    end
  end

  // Saturating update for the band addressed by the stage-1 beat.
  always_comb begin
    first_s = ~hit_r[s1_band_r] | done_r;
    ovf_s   = 1'b0;
    for (int q = 0; q < 4; q++) begin
      upd_s[q] = sat_add(acc_r[q][s1_band_r], s1_sum_r[q], first_s);
      ovf_s    = ovf_s | upd_s[q][ACC_WIDTH];
    end
  end

  // Per-band accumulators; a band's first beat of an integration loads instead of adding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r <= 1'b0;
      hit_r  <= {BANDS{1'b0}};
      sat_r  <= {BANDS{1'b0}};
      for (int q = 0; q < 4; q++)
        for (int b = 0; b < BANDS; b++) acc_r[q][b] <= {ACC_WIDTH{1'b0}};
    end else begin
      done_r <= s1_valid_r & s1_end_r;
      if (done_r) hit_r <= {BANDS{1'b0}};
      if (s1_valid_r) begin
        hit_r[s1_band_r] <= 1'b1;
        sat_r[s1_band_r] <= (first_s ? 1'b0 : sat_r[s1_band_r]) | ovf_s;
        for (int q = 0; q < 4; q++) acc_r[q][s1_band_r] <= upd_s[q][ACC_WIDTH-1:0];
      end
    end
  end

  assign next_band_s = band_number + BW'(1);

  // Output FSM: capture a finished integration into the shadow and stream its bands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state_r <= O_EMPTY;
      r11 <= {ACC_WIDTH{1'b0}};
      r22 <= {ACC_WIDTH{1'b0}};
      r12_re <= {ACC_WIDTH{1'b0}};
      r12_im <= {ACC_WIDTH{1'b0}};
      band_number <= {BW{1'b0}};
      dout_sat <= 1'b0;
      dout_valid <= 1'b0;
      overrun <= 1'b0;
      sh_sat_r <= {BANDS{1'b0}};
      for (int q = 0; q < 4; q++)
        for (int b = 0; b < BANDS; b++) shadow_r[q][b] <= {ACC_WIDTH{1'b0}};
    end else begin
      if (done_r && (out_state_r != O_EMPTY)) overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
      case (out_state_r)
        O_EMPTY: begin
          if (done_r) begin
            for (int q = 0; q < 4; q++)
              for (int b = 0; b < BANDS; b++)
                shadow_r[q][b] <= hit_r[b] ? acc_r[q][b] : {ACC_WIDTH{1'b0}};
            sh_sat_r    <= hit_r & sat_r;
            out_state_r <= O_LOAD;
          end
        end
        O_LOAD: begin
          r11 <= shadow_r[0][0];
          r22 <= shadow_r[1][0];
          r12_re <= shadow_r[2][0];
          r12_im <= shadow_r[3][0];
          dout_sat <= sh_sat_r[0];
          band_number <= {BW{1'b0}};
          dout_valid <= 1'b1;
          out_state_r <= O_SEND;
        end
        O_SEND: begin
          if (dout_ready) begin
            if (band_number == BW'(BANDS - 1)) begin
              dout_valid  <= 1'b0;
              band_number <= {BW{1'b0}};
              out_state_r <= O_EMPTY;
            end else begin
              band_number <= next_band_s;
              r11 <= shadow_r[0][next_band_s];
              r22 <= shadow_r[1][next_band_s];
              r12_re <= shadow_r[2][next_band_s];
              r12_im <= shadow_r[3][next_band_s];
              dout_sat <= sh_sat_r[next_band_s];
            end
          end
        end
        default: out_state_r <= O_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_band_corr_acc.sv
// Directed bench for band_corr_acc: ACC_WIDTH=20, 4 lanes, 16 beats per spectrum,
// 4 bands of 4 beats each. Accepted output beats are collected and compared.
module tb_band_corr_acc;
  localparam int DW = 35;
  localparam int P  = 4;
  localparam int AW = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic [P*DW-1:0] pow0, pow1, corr_re, corr_im;
  logic din_valid, sync, clr_overrun, dout_ready;
  logic [15:0] acc_len;
  logic signed [AW-1:0] r11, r22, r12_re, r12_im;
  logic [1:0] band_number;
  logic dout_sat, dout_valid, overrun;

  logic [DW-1:0] v_p0, v_p1, v_re, v_im, hot_p0;
  int hot_band;
  int n_checks = 0;
  int n_fail = 0;
  int lat;

  typedef struct {
    longint band; longint r11; longint r22; longint re; longint im; longint sat;
  } obs_t;
  obs_t q[$];

  band_corr_acc #(.ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .pow0(pow0), .pow1(pow1), .corr_re(corr_re),
    .corr_im(corr_im), .din_valid(din_valid), .sync(sync), .acc_len(acc_len),
    .clr_overrun(clr_overrun), .r11(r11), .r22(r22), .r12_re(r12_re),
    .r12_im(r12_im), .band_number(band_number), .dout_sat(dout_sat),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Record every accepted output beat, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && dout_valid && dout_ready) begin
      obs_t o;
      o.band = band_number; o.r11 = r11; o.r22 = r22;
      o.re = r12_re; o.im = r12_im; o.sat = dout_sat;
      q.push_back(o);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input longint eb, input longint e11,
                            input longint e22, input longint ere, input longint eim,
                            input longint esat);
    obs_t o;
    check_eq({tag, "_present"}, longint'(q.size() > 0), 1);
    if (q.size() > 0) begin
      o = q.pop_front();
      check_eq({tag, "_band"}, o.band, eb);
      check_eq({tag, "_r11"}, o.r11, e11);
      check_eq({tag, "_r22"}, o.r22, e22);
      check_eq({tag, "_r12re"}, o.re, ere);
      check_eq({tag, "_r12im"}, o.im, eim);
      check_eq({tag, "_sat"}, o.sat, esat);
    end
  endtask

  task automatic beat(input logic s, input logic [DW-1:0] p0v);
    pow0 = {P{p0v}}; pow1 = {P{v_p1}}; corr_re = {P{v_re}}; corr_im = {P{v_im}};
    sync = s; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0; sync = 1'b0;
  endtask

  task automatic send_spec(input int n);
    for (int i = 0; i < n; i++) begin
      if ((i / 4) == hot_band) beat(i == 0, hot_p0);
      else beat(i == 0, v_p0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int kk[4];

  initial begin
    rst_n = 1'b0; din_valid = 1'b0; sync = 1'b0; clr_overrun = 1'b0; dout_ready = 1'b0;
    acc_len = 16'd1; hot_band = -1; hot_p0 = 35'd0;
    v_p0 = 35'd1; v_p1 = 35'd2; v_re = 35'd3; v_im = -35'sd2;
    pow0 = '0; pow1 = '0; corr_re = '0; corr_im = '0;
    idle(3);

    // Reset state
    @(negedge clk);
    check_eq("rst_valid", dout_valid, 0);
    check_eq("rst_r11", r11, 0);
    check_eq("rst_band", band_number, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_sat", dout_sat, 0);
    rst_n = 1'b1;
    idle(2);

    // acc_len=1, one spectrum, latency
    dout_ready = 1'b1;
    send_spec(16);
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); @(negedge clk);
      if (dout_valid) begin lat = i; break; end
    end
    check_eq("t2_latency", lat, 3);
    idle(8);
    check_eq("t2_count", q.size(), 4);
    for (int b = 0; b < 4; b++) check_beat($sformatf("t2_b%0d", b), b, 16, 32, 48, -32, 0);
    @(negedge clk);
    check_eq("t2_idle_valid", dout_valid, 0);

    // acc_len=3, six spectra -> two bursts
    acc_len = 16'd3;
    repeat (6) send_spec(16);
    idle(10);
    check_eq("t3_count", q.size(), 8);
    for (int i = 0; i < 8; i++) check_beat($sformatf("t3_%0d", i), i % 4, 48, 96, 144, -96, 0);
    @(negedge clk);
    check_eq("t3_band_wrap", band_number, 0);

    // Backpressure and overrun
    acc_len = 16'd1; dout_ready = 1'b0;
    send_spec(16);
    idle(6);
    @(negedge clk);
    check_eq("t4_valid_a", dout_valid, 1);
    check_eq("t4_band_a", band_number, 0);
    check_eq("t4_r11_a", r11, 16);
    check_eq("t4_im_a", r12_im, -32);
    v_p0 = 35'd7;
    send_spec(16);
    idle(6);
    @(negedge clk);
    check_eq("t4_r11_hold", r11, 16);
    check_eq("t4_band_hold", band_number, 0);
    check_eq("t4_valid_hold", dout_valid, 1);
    check_eq("t4_overrun", overrun, 1);
    v_p0 = 35'd1; dout_ready = 1'b1;
    idle(8);
    check_eq("t4_count", q.size(), 4);
    for (int b = 0; b < 4; b++) check_beat($sformatf("t4_b%0d", b), b, 16, 32, 48, -32, 0);
    @(negedge clk);
    check_eq("t4_dropped", dout_valid, 0);
    check_eq("t4_overrun_sticky", overrun, 1);
    clr_overrun = 1'b1;
    idle(1);
    clr_overrun = 1'b0;
    @(negedge clk);
    check_eq("t4_overrun_clr", overrun, 0);

    // Saturation in band 2 only
    hot_band = 2; hot_p0 = 35'h3_FFFF_FFFF;
    send_spec(16);
    idle(8);
    hot_band = -1;
    check_eq("t5_count", q.size(), 4);
    for (int b = 0; b < 4; b++) begin
      if (b == 2) check_beat("t5_b2", 2, 524287, 32, 48, -32, 1);
      else check_beat($sformatf("t5_b%0d", b), b, 16, 32, 48, -32, 0);
    end

    // Short spectrum and extra beats past the end of a spectrum
    acc_len = 16'd3;
    send_spec(10);
    send_spec(16);
    repeat (3) beat(1'b0, 35'd100);
    send_spec(16);
    idle(10);
    kk[0] = 12; kk[1] = 12; kk[2] = 10; kk[3] = 8;
    check_eq("t6_count", q.size(), 4);
    for (int b = 0; b < 4; b++)
      check_beat($sformatf("t6_b%0d", b), b, 4*kk[b], 8*kk[b], 12*kk[b], -8*kk[b], 0);

    // Reset in the middle of an integration
    acc_len = 16'd1; v_p0 = 35'd9;
    send_spec(8);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("t7_rst_valid", dout_valid, 0);
    check_eq("t7_rst_r11", r11, 0);
    check_eq("t7_rst_band", band_number, 0);
    idle(2);
    rst_n = 1'b1; v_p0 = 35'd1;
    idle(1);
    send_spec(16);
    idle(8);
    check_eq("t7_count", q.size(), 4);
    for (int b = 0; b < 4; b++) check_beat($sformatf("t7_b%0d", b), b, 16, 32, 48, -32, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
